if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-low: 0 resets immediately, release is synchronous to clk.
REQ-004 hazard  input  1  stall from hazard unit; 1 = downstream IF/ID register holds, current instruction not consumed.
REQ-005 IF_flush  input  1  branch/jump redirect; 1 = discard current fetch and restart at branchTarget.
REQ-006 branchTarget  input  32  redirect address, sampled only when IF_flush=1.
REQ-007 imemReq  output  1  instruction-memory request.
REQ-008 imemAddr  output  32  word-aligned fetch address, valid while imemReq=1.
REQ-009 imemAck  input  1  memory response; 1 = imemData holds the word at the imemAddr presented this cycle.
REQ-010 imemData  input  32  instruction word, qualified by imemAck.
REQ-011 pcOutput  output  32  PC+4 of the presented instruction, to IF/ID pcInput.
REQ-012 instructionOutput  output  32  presented instruction, to IF/ID instructionInput; 0 (NOP) when no valid instruction.
REQ-013 fetchValid  output  1  1 = instructionOutput/pcOutput hold a fetched instruction.

Function
REQ-014 Internal state: pc (32), instrBuf (32), FSM state {FETCH, VALID}.
REQ-015 FETCH: imemReq=1, imemAddr=pc, fetchValid=0, instructionOutput=0, pcOutput=0.
REQ-016 FETCH, imemAck=1, IF_flush=0 at edge -> instrBuf<=imemData, state<=VALID, pc unchanged.
REQ-017 FETCH, imemAck=0 -> remain in FETCH, imemReq stays 1, imemAddr stable; no timeout.
REQ-018 VALID: imemReq=0, imemAddr=pc, fetchValid=1, instructionOutput=instrBuf, pcOutput=pc+4.
REQ-019 VALID, hazard=0, IF_flush=0 at edge -> instruction consumed: pc<=pc+4, state<=FETCH.
REQ-020 VALID, hazard=1, IF_flush=0 -> hold: pc, instrBuf, state and all outputs unchanged.
REQ-021 Consumption in FETCH (fetchValid=0) SHALL NOT advance pc; IF/ID captures the NOP.
REQ-022 IF_flush=1 at edge, any state -> pc<={branchTarget[31:2],2'b00}, state<=FETCH, instrBuf discarded; overrides hazard and imemAck in the same cycle.
REQ-023 imemAck in the flush cycle SHALL be ignored (data not captured).
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0), no error flag.
REQ-025 Minimum latency: FETCH entry to fetchValid=1 is 1 cycle with same-cycle imemAck; throughput max one instruction per 2 cycles.
REQ-026 imemAck while in VALID SHALL be ignored.
REQ-027 Outputs SHALL be decoded from registered state only, except none depend combinationally on hazard, IF_flush or imemAck.

Reset
REQ-028 reset=0 -> pc<=RESET_PC, instrBuf<=0, state<=FETCH immediately, regardless of clk.
REQ-029 During reset: imemReq=1, imemAddr=RESET_PC, fetchValid=0, instructionOutput=0, pcOutput=0.
REQ-030 Reset asserted mid-fetch or in VALID SHALL abandon that instruction; first fetch after release is from RESET_PC.

Verification
REQ-031 Reset release, imemAck=1 every cycle, hazard=0, data=0x20080001 at 0 -> next cycle fetchValid=1, instructionOutput=0x20080001, pcOutput=4; following cycle imemAddr=4.
REQ-032 In VALID at pc=0x10, hazard=1 for 3 cycles -> outputs frozen at pc+4=0x14, imemReq=0; hazard=0 -> next cycle imemAddr=0x14, fetchValid=0.
REQ-033 FETCH at pc=0x8, imemAck=0 for 4 cycles then 1 -> imemAddr=0x8 stable throughout, fetchValid rises the cycle after ack.
REQ-034 VALID with hazard=1 and IF_flush=1, branchTarget=0x43 -> next cycle state FETCH, imemAddr=0x40, fetchValid=0.
REQ-035 FETCH at pc=0xFFFF_FFFC, ack -> pcOutput=0; after consumption imemAddr=0.
REQ-036 reset=0 asserted between clk edges while VALID -> fetchValid=0, imemAddr=RESET_PC before next edge.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: fetches one word per instruction and presents it
// to the IF/ID register until the pipeline consumes it.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   hazard            1 = IF/ID holds, presented instruction not consumed
//   IF_flush          1 = discard current fetch, restart at branchTarget
//   branchTarget      redirect address (low two bits forced to zero)
//   imemReq/imemAddr  instruction-memory request and word address
//   imemAck/imemData  memory response, data valid when imemAck=1
//   pcOutput          PC+4 of the presented instruction (0 when none)
//   instructionOutput presented instruction (0 / NOP when none)
//   fetchValid        1 = outputs hold a fetched instruction
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard,
    input  logic        IF_flush,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] pcOutput,
    output logic [31:0] instructionOutput,
    output logic        fetchValid
);

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] instrBuf;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a flush overrides both ack and hazard.
    always_comb begin
        state_next = state;
        if (IF_flush) begin
            state_next = FETCH;
        end else begin
            unique case (state)
                FETCH: if (imemAck) state_next = VALID;
                VALID: if (!hazard) state_next = FETCH;
                default: state_next = FETCH;
            endcase
        end
    end

    // Datapath: pc only advances when a valid instruction is consumed,
    // so a NOP captured by IF/ID during FETCH never skips a word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            instrBuf <= '0;
        end else if (IF_flush) begin
            pc       <= {branchTarget[31:2], 2'b00};
            instrBuf <= '0;
        end else if (state == FETCH) begin
            if (imemAck) begin
                instrBuf <= imemData;
            end
        end else if (!hazard) begin
            pc <= pc + 32'd4;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        imemReq           = 1'b1;
        imemAddr          = pc;
        fetchValid        = 1'b0;
        instructionOutput = '0;
        pcOutput          = '0;
        if (state == VALID) begin
            imemReq           = 1'b0;
            fetchValid        = 1'b1;
            instructionOutput = instrBuf;
            pcOutput          = pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios followed by randomized traffic,
// all compared against a transaction-level reference model.
module tb_if_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        hazard;
    logic        IF_flush;
    logic [31:0] branchTarget;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] pcOutput;
    logic [31:0] instructionOutput;
    logic        fetchValid;

    int tests;
    int failed;

    // Reference model: the address of the word being fetched or presented,
    // whether an instruction is currently presented, and that instruction.
    logic [31:0] m_pc;
    bit          m_have;
    logic [31:0] m_instr;

    if_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk),
        .reset(reset),
        .hazard(hazard),
        .IF_flush(IF_flush),
        .branchTarget(branchTarget),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemAck(imemAck),
        .imemData(imemData),
        .pcOutput(pcOutput),
        .instructionOutput(instructionOutput),
        .fetchValid(fetchValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect32(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RPC;
        m_have  = 1'b0;
        m_instr = '0;
    endtask

    // Compare every output against what the model says is presented.
    task automatic chk(input string tag);
        expect32({tag, ".req"}, {31'd0, imemReq}, {31'd0, !m_have});
        expect32({tag, ".addr"}, imemAddr, m_pc);
        expect32({tag, ".valid"}, {31'd0, fetchValid}, {31'd0, m_have});
        expect32({tag, ".instr"}, instructionOutput,
                 m_have ? m_instr : 32'd0);
        expect32({tag, ".pcout"}, pcOutput,
                 m_have ? m_pc + 32'd4 : 32'd0);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic cyc(input logic h, input logic f, input logic [31:0] bt,
                       input logic a, input logic [31:0] d,
                       input string tag);
        hazard       = h;
        IF_flush     = f;
        branchTarget = bt;
        imemAck      = a;
        imemData     = d;
        @(posedge clk);
        if (f) begin
            m_pc   = bt & 32'hFFFF_FFFC;
            m_have = 1'b0;
        end else if (!m_have) begin
            if (a) begin
                m_have  = 1'b1;
                m_instr = d;
            end
        end else if (!h) begin
            m_pc   = m_pc + 32'd4;
            m_have = 1'b0;
        end
        #1;
        chk(tag);
    endtask

    // Reset asserted between edges, checked before the next edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        reset        = 1'b0;
        hazard       = 1'b0;
        IF_flush     = 1'b0;
        branchTarget = '0;
        imemAck      = 1'b0;
        imemData     = '0;
        model_reset();
        #3;
        chk("reset");
        @(negedge clk);
        chk("reset_hold");
        reset = 1'b1;

        // First fetch after release with same-cycle ack.
        cyc(0, 0, 0, 1, 32'h2008_0001, "first");
        expect32("first.valid", {31'd0, fetchValid}, 32'd1);
        expect32("first.instr", instructionOutput, 32'h2008_0001);
        expect32("first.pcout", pcOutput, 32'd4);
        cyc(0, 0, 0, 1, 32'h1111_1111, "consume");
        expect32("consume.addr", imemAddr, 32'd4);

        // Hazard hold at pc=0x10.
        cyc(0, 1, 32'h10, 1, 32'hDEAD_BEEF, "flush10");
        cyc(0, 0, 0, 1, 32'hCAFE_0010, "fetch10");
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 1, $urandom, "hold");
            expect32("hold.pcout", pcOutput, 32'h14);
            expect32("hold.req", {31'd0, imemReq}, 32'd0);
            expect32("hold.instr", instructionOutput, 32'hCAFE_0010);
        end
        cyc(0, 0, 0, 0, 0, "release");
        expect32("release.addr", imemAddr, 32'h14);
        expect32("release.valid", {31'd0, fetchValid}, 32'd0);

        // Slow memory at pc=0x8; ack during flush cycle is ignored.
        cyc(0, 1, 32'h8, 1, 32'hBAD0_BAD0, "flush8");
        for (int i = 0; i < 4; i++) begin
            cyc($urandom_range(0, 1), 0, 0, 0, $urandom, "wait");
            expect32("wait.addr", imemAddr, 32'h8);
        end
        cyc(0, 0, 0, 1, 32'h0000_0808, "ack8");
        expect32("ack8.valid", {31'd0, fetchValid}, 32'd1);

        // Flush overrides hazard, target realigned.
        cyc(1, 1, 32'h43, 1, 32'h5555_5555, "flush43");
        expect32("flush43.addr", imemAddr, 32'h40);
        expect32("flush43.valid", {31'd0, fetchValid}, 32'd0);

        // PC wrap at the top of the address space.
        cyc(0, 1, 32'hFFFF_FFFC, 0, 0, "flushtop");
        cyc(0, 0, 0, 1, 32'h7777_0000, "acktop");
        expect32("acktop.pcout", pcOutput, 32'd0);
        cyc(0, 0, 0, 0, 0, "wrap");
        expect32("wrap.addr", imemAddr, 32'd0);

        // Asynchronous reset while presenting an instruction.
        cyc(0, 1, 32'h100, 0, 0, "flush100");
        cyc(0, 0, 0, 1, 32'h0123_4567, "ack100");
        async_reset("async");
        expect32("async.valid", {31'd0, fetchValid}, 32'd0);
        expect32("async.addr", imemAddr, RPC);
        cyc(0, 0, 0, 1, 32'h8888_0000, "after_rst");
        expect32("after_rst.pcout", pcOutput, RPC + 32'd4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt;
            bt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15)
                                              : $urandom;
            cyc($urandom_range(0, 1), $urandom_range(0, 7) == 0, bt,
                $urandom_range(0, 2) != 0, $urandom, "rand");
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
